// File: rtl/mux.sv
// 4:1 mux with registered output, registered select and a saturating select-change counter.
// Latency: y is combinational; y_q, s_q, sel_chg and chg_cnt are one cycle. No backpressure.
// Define MUX_GLITCH_FILTER_EN to gate y_q until the select has been stable for two edges.
module mux #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       d,
  input  logic [1:0]       s,
  output logic             y,
  output logic             y_q,
  output logic [1:0]       s_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] chg_cnt
);

  logic sel_diff;
  logic cnt_max;

  assign y        = d[s];
  assign sel_diff = (s != s_q);
  assign cnt_max  = (chg_cnt == {CNT_W{1'b1}});

`ifdef MUX_GLITCH_FILTER_EN
  // Remembers whether s matched s_q at the previous edge; cleared on reset so
  // the first y_q update lands no earlier than the second edge after release.
  logic sel_eq_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_eq_d <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      sel_eq_d <= ~sel_diff;
      if (~sel_diff && sel_eq_d) begin
        y_q <= y;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= 2'b00;
      sel_chg <= 1'b0;
      chg_cnt <= '0;
    end else begin
      s_q     <= s;
      sel_chg <= sel_diff;
      if (sel_diff && !cnt_max) begin
        chg_cnt <= chg_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: combinational select, reset, registered paths and counter saturation.
module tb_mux;

  localparam int CNT_W = 8;
`ifdef MUX_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       d;
  logic [1:0]       s;
  logic             y;
  logic             y_q;
  logic [1:0]       s_q;
  logic             sel_chg;
  logic [CNT_W-1:0] chg_cnt;

  int vecs = 0;
  int errs = 0;
  int exp_cnt;

  mux #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .s       (s),
    .y       (y),
    .y_q     (y_q),
    .s_q     (s_q),
    .sel_chg (sel_chg),
    .chg_cnt (chg_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic yq, input logic [1:0] sq,
                            input logic sc, input logic [CNT_W-1:0] cnt);
    check({tag, ".y_q"}, 16'(y_q), 16'(yq));
    check({tag, ".s_q"}, 16'(s_q), 16'(sq));
    check({tag, ".sel_chg"}, 16'(sel_chg), 16'(sc));
    check({tag, ".chg_cnt"}, 16'(chg_cnt), 16'(cnt));
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_y;

    // Reset held for two edges with s=11, d=F
    reset = 1'b1; s = 2'b11; d = 4'hF;
    tick();
    check_regs("rst_e1", 1'b0, 2'b00, 1'b0, 8'd0);
    check("rst_e1.y", 16'(y), 16'd1);
    tick();
    check_regs("rst_e2", 1'b0, 2'b00, 1'b0, 8'd0);
    check("rst_e2.y", 16'(y), 16'd1);

    // y tracks d during reset
    d = 4'h7; #1;
    check("rst_d_chg.y", 16'(y), 16'd0);

    // Select sweep with d=1010, still in reset
    d = 4'b1010;
    pat = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      exp_y = pat >> i;
      check($sformatf("sweep_s%0d.y", i), 16'(y), 16'(exp_y[0]));
      #9;
    end
    tick();
    check_regs("sweep_rst", 1'b0, 2'b00, 1'b0, 8'd0);

    // First edge after release compares against s_q=00: s=10 counts as a change
    reset = 1'b0; d = 4'b0100; s = 2'b10;
    tick();
    check_regs("rel_e1", FILT ? 1'b0 : 1'b1, 2'b10, 1'b1, 8'd1);
    tick();
    check_regs("rel_e2", FILT ? 1'b0 : 1'b1, 2'b10, 1'b0, 8'd1);
    s = 2'b00; #1;
    check("s00.y", 16'(y), 16'd0);
    tick();
    check_regs("s00_e1", 1'b0, 2'b00, 1'b1, 8'd2);

    // 00->11->00->11 on consecutive edges with d=1000, then 11 held
    d = 4'b1000;
    s = 2'b11;
    tick();
    check_regs("g_e1", FILT ? 1'b0 : 1'b1, 2'b11, 1'b1, 8'd3);
    s = 2'b00;
    tick();
    check_regs("g_e2", 1'b0, 2'b00, 1'b1, 8'd4);
    s = 2'b11;
    tick();
    check_regs("g_e3", FILT ? 1'b0 : 1'b1, 2'b11, 1'b1, 8'd5);
    tick();
    check_regs("g_hold1", FILT ? 1'b0 : 1'b1, 2'b11, 1'b0, 8'd5);
    tick();
    check_regs("g_hold2", 1'b1, 2'b11, 1'b0, 8'd5);

    // Reset mid-operation with chg_cnt=5, then counting resumes from 0
    reset = 1'b1;
    tick();
    check_regs("mid_rst", 1'b0, 2'b00, 1'b0, 8'd0);
    check("mid_rst.y", 16'(y), 16'd1);
    reset = 1'b0;
    tick();
    check_regs("resume", FILT ? 1'b0 : 1'b1, 2'b11, 1'b1, 8'd1);

    // Toggle s every edge for 300 edges: sel_chg stays high, counter saturates
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      s = (i % 2 == 0) ? 2'b00 : 2'b01;
      tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check($sformatf("tog%0d.sel_chg", i), 16'(sel_chg), 16'd1);
      check($sformatf("tog%0d.chg_cnt", i), 16'(chg_cnt), 16'(exp_cnt));
    end
    check("tog_end.chg_cnt", 16'(chg_cnt), 16'd255);

    // Held select after saturation: pulse drops, counter holds
    tick();
    check_regs("sat_hold", FILT ? 1'b0 : d[s], s, 1'b0, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
